// File: rtl/player_cmd_arbiter_pkg.sv
// Shared constants, FSM state type and small helpers for the player command arbiter.
package player_pkg;

  localparam int NUM_REQ = 3;

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_HEAL    = 4'd1;
  localparam logic [3:0] OP_DMG     = 4'd2;
  localparam logic [3:0] OP_ATK_ADD = 4'd3;
  localparam logic [3:0] OP_ATK_SET = 4'd4;
  localparam logic [3:0] OP_MOVE    = 4'd5;
  localparam logic [3:0] OP_HP_SET  = 4'd6;

  localparam logic [1:0] GRANT_NONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    MOVE_HOLD = 2'd2
  } state_e;

  // Addition modulo the requester count; both operands are in 0..2.
  function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

endpackage

// File: rtl/player_cmd_arbiter_if.sv
// Requester handshake and player-datapath output bundle for player_cmd_arbiter.
interface player_cmd_arbiter_if;
  import player_pkg::*;

  logic [NUM_REQ-1:0]    req_valid;
  logic [16*NUM_REQ-1:0] req_instr;
  logic [NUM_REQ-1:0]    req_ready;
  logic [15:0]           instr_out;
  logic [1:0]            grant_id;
  logic                  drop_pulse;
  logic                  iframe_active;

  modport master (
    output req_valid, req_instr,
    input  req_ready, instr_out, grant_id, drop_pulse, iframe_active
  );

  modport slave (
    input  req_valid, req_instr,
    output req_ready, instr_out, grant_id, drop_pulse, iframe_active
  );

endinterface

// File: rtl/player_cmd_arbiter_rr_arbiter3.sv
// Three-way round-robin selector: first requester at or after ptr wins.
module rr_arbiter3
  import player_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt,
  output logic [1:0] idx
);

  logic [2:0] rot;
  logic [1:0] base;
  logic [1:0] off;

  always_comb begin
    base = (ptr == 2'd3) ? 2'd0 : ptr;
    // rot[i] is the request at position base+i, so bit 0 has top priority
    case (base)
      2'd1:    rot = {req[0], req[2], req[1]};
      2'd2:    rot = {req[1], req[0], req[2]};
      default: rot = req;
    endcase

    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else             off = 2'd2;

    idx = GRANT_NONE;
    gnt = 3'b000;
    if (|rot) begin
      idx = mod3_add(base, off);
      gnt = 3'b001 << idx;
    end
  end

endmodule

// File: rtl/player_cmd_arbiter.sv
// Arbitrates three command requesters onto the player instruction bus.
// Optional damage-immunity counter is built when PLAYER_IFRAME_EN is defined.
module player_cmd_arbiter
  import player_pkg::*;
#(
  parameter int IFRAME_TICKS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick_10hz,
  player_cmd_arbiter_if.slave  bus
);

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic        drop_q, drop_d;

  logic [2:0]  arb_gnt;
  logic [1:0]  arb_idx;
  logic        accept;
  logic [15:0] sel_instr;
  logic [3:0]  sel_op;
  logic        iframe_block;

  rr_arbiter3 u_rr (
    .req (bus.req_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_comb begin
    case (arb_idx)
      2'd0:    sel_instr = bus.req_instr[15:0];
      2'd1:    sel_instr = bus.req_instr[31:16];
      2'd2:    sel_instr = bus.req_instr[47:32];
      default: sel_instr = 16'h0000;
    endcase
  end

  assign sel_op        = sel_instr[15:12];
  assign accept        = (state_q == IDLE) && rst_n && (|bus.req_valid);
  assign bus.req_ready = accept ? arb_gnt : 3'b000;

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    drop_d   = 1'b0;
    case (state_q)
      IDLE: begin
        instr_d = 16'h0000;
        grant_d = GRANT_NONE;
        if (accept) begin
          rr_ptr_d = mod3_add(arb_idx, 2'd1);
          case (sel_op)
            OP_MOVE: begin
              state_d = MOVE_HOLD;
              instr_d = sel_instr;
              grant_d = arb_idx;
            end
            OP_HEAL, OP_ATK_ADD, OP_ATK_SET, OP_HP_SET: begin
              state_d = ISSUE;
              instr_d = sel_instr;
              grant_d = arb_idx;
            end
            OP_DMG: begin
              if (iframe_block) begin
                drop_d = 1'b1;
              end else begin
                state_d = ISSUE;
                instr_d = sel_instr;
                grant_d = arb_idx;
              end
            end
            default: drop_d = 1'b1;
          endcase
        end
      end
      ISSUE: begin
        state_d = IDLE;
        instr_d = 16'h0000;
        grant_d = GRANT_NONE;
      end
      MOVE_HOLD: begin
        // A tick seen here ends the hold; the accept-cycle tick was in IDLE and is ignored
        if (tick_10hz) begin
          state_d = IDLE;
          instr_d = 16'h0000;
          grant_d = GRANT_NONE;
        end
      end
      default: begin
        state_d = IDLE;
        instr_d = 16'h0000;
        grant_d = GRANT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      instr_q  <= 16'h0000;
      grant_q  <= GRANT_NONE;
      rr_ptr_q <= 2'd0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      drop_q   <= drop_d;
    end
  end

`ifdef PLAYER_IFRAME_EN
  logic [7:0] iframe_q, iframe_d;
  logic       dmg_issue;

  assign dmg_issue = accept && (sel_op == OP_DMG) && !iframe_block;

  // An issued damage reloads the window even if a tick arrives in the same cycle
  always_comb begin
    iframe_d = iframe_q;
    if (dmg_issue)
      iframe_d = 8'(IFRAME_TICKS);
    else if (tick_10hz && (iframe_q != 8'd0))
      iframe_d = iframe_q - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) iframe_q <= 8'd0;
    else        iframe_q <= iframe_d;
  end

  assign iframe_block      = (iframe_q != 8'd0);
  assign bus.iframe_active = iframe_block;
`else
  assign iframe_block      = 1'b0;
  assign bus.iframe_active = 1'b0;
`endif

  assign bus.instr_out  = instr_q;
  assign bus.grant_id   = grant_q;
  assign bus.drop_pulse = drop_q;

endmodule

// File: tb/tb_player_cmd_arbiter.sv
// Directed self-checking bench for player_cmd_arbiter (IFRAME_TICKS=3).
module tb_player_cmd_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic tick;
  int   n_tests = 0;
  int   n_fail  = 0;

  player_cmd_arbiter_if bus();

  player_cmd_arbiter #(.IFRAME_TICKS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_10hz (tick),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick = 1'b0;
    bus.req_valid = 3'b111;
    bus.req_instr = {16'h1070, 16'h1060, 16'h1050};
    step(); step(); #1;
    n_tests++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready got %b want 000", bus.req_ready); end
    n_tests++; if (bus.instr_out !== 16'h0000) begin n_fail++; $display("FAIL reset_instr got %h want 0000", bus.instr_out); end
    n_tests++; if (bus.grant_id !== 2'd3) begin n_fail++; $display("FAIL reset_grant got %0d want 3", bus.grant_id); end
    n_tests++; if (bus.drop_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_drop got %b want 0", bus.drop_pulse); end
    n_tests++; if (bus.iframe_active !== 1'b0) begin n_fail++; $display("FAIL reset_iframe got %b want 0", bus.iframe_active); end
    bus.req_valid = 3'b000;
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    bus.req_instr = {16'h1070, 16'h1060, 16'h1050};
    bus.req_valid = 3'b111; #1;
    n_tests++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL rr_c0_ready got %b want 001", bus.req_ready); end
    step(); bus.req_valid = 3'b110; #1;
    n_tests++; if (bus.instr_out !== 16'h1050 || bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL rr_c1 got %h/%0d want 1050/0", bus.instr_out, bus.grant_id); end
    n_tests++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL rr_c1_ready got %b want 000", bus.req_ready); end
    step();
    n_tests++; if (bus.instr_out !== 16'h0000 || bus.grant_id !== 2'd3) begin n_fail++; $display("FAIL rr_c2 got %h/%0d want 0000/3", bus.instr_out, bus.grant_id); end
    n_tests++; if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL rr_c2_ready got %b want 010", bus.req_ready); end
    step(); bus.req_valid = 3'b100; #1;
    n_tests++; if (bus.instr_out !== 16'h1060 || bus.grant_id !== 2'd1) begin n_fail++; $display("FAIL rr_c3 got %h/%0d want 1060/1", bus.instr_out, bus.grant_id); end
    step();
    n_tests++; if (bus.instr_out !== 16'h0000 || bus.req_ready !== 3'b100) begin n_fail++; $display("FAIL rr_c4 got %h/%b want 0000/100", bus.instr_out, bus.req_ready); end
    step(); bus.req_valid = 3'b000; #1;
    n_tests++; if (bus.instr_out !== 16'h1070 || bus.grant_id !== 2'd2) begin n_fail++; $display("FAIL rr_c5 got %h/%0d want 1070/2", bus.instr_out, bus.grant_id); end
    step();
    n_tests++; if (bus.instr_out !== 16'h0000 || bus.grant_id !== 2'd3) begin n_fail++; $display("FAIL rr_c6 got %h/%0d want 0000/3", bus.instr_out, bus.grant_id); end
  endtask

  task automatic test_move_hold();
    bus.req_instr = {16'h5010, 16'h0000, 16'h1020};
    bus.req_valid = 3'b100; tick = 1'b1; #1;
    n_tests++; if (bus.req_ready !== 3'b100) begin n_fail++; $display("FAIL mv_c0_ready got %b want 100", bus.req_ready); end
    step(); bus.req_valid = 3'b000; tick = 1'b0; #1;
    n_tests++; if (bus.instr_out !== 16'h5010 || bus.grant_id !== 2'd2) begin n_fail++; $display("FAIL mv_c1 got %h/%0d want 5010/2", bus.instr_out, bus.grant_id); end
    for (int c = 2; c <= 7; c++) begin
      step();
      if (c == 3) bus.req_valid = 3'b001;
      if (c == 7) tick = 1'b1;
      #1;
      n_tests++; if (bus.instr_out !== 16'h5010 || bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL mv_hold_c%0d got %h/%b want 5010/000", c, bus.instr_out, bus.req_ready); end
    end
    step(); tick = 1'b0; #1;
    n_tests++; if (bus.instr_out !== 16'h0000 || bus.grant_id !== 2'd3) begin n_fail++; $display("FAIL mv_c8 got %h/%0d want 0000/3", bus.instr_out, bus.grant_id); end
    n_tests++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL mv_c8_ready got %b want 001", bus.req_ready); end
    step(); bus.req_valid = 3'b000; #1;
    n_tests++; if (bus.instr_out !== 16'h1020 || bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL mv_c9 got %h/%0d want 1020/0", bus.instr_out, bus.grant_id); end
    step();
  endtask

  task automatic test_drop();
    bus.req_instr = {16'h0000, 16'h9000, 16'h0000};
    bus.req_valid = 3'b010; #1;
    n_tests++; if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL drop9_ready got %b want 010", bus.req_ready); end
    step(); bus.req_valid = 3'b000; #1;
    n_tests++; if (bus.drop_pulse !== 1'b1) begin n_fail++; $display("FAIL drop9_pulse got %b want 1", bus.drop_pulse); end
    n_tests++; if (bus.instr_out !== 16'h0000 || bus.grant_id !== 2'd3) begin n_fail++; $display("FAIL drop9_bus got %h/%0d want 0000/3", bus.instr_out, bus.grant_id); end
    step();
    n_tests++; if (bus.drop_pulse !== 1'b0) begin n_fail++; $display("FAIL drop9_end got %b want 0", bus.drop_pulse); end
    bus.req_valid = 3'b100; #1;
    n_tests++; if (bus.req_ready !== 3'b100) begin n_fail++; $display("FAIL drop0_ready got %b want 100", bus.req_ready); end
    step(); bus.req_valid = 3'b000; #1;
    n_tests++; if (bus.drop_pulse !== 1'b1 || bus.instr_out !== 16'h0000) begin n_fail++; $display("FAIL drop0 got %b/%h want 1/0000", bus.drop_pulse, bus.instr_out); end
    step();
  endtask

  task automatic test_reset_during_move();
    bus.req_instr = {16'h0000, 16'h5030, 16'h0000};
    bus.req_valid = 3'b010; #1;
    n_tests++; if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL rstmv_ready got %b want 010", bus.req_ready); end
    step(); bus.req_valid = 3'b000; #1;
    n_tests++; if (bus.instr_out !== 16'h5030) begin n_fail++; $display("FAIL rstmv_c1 got %h want 5030", bus.instr_out); end
    step(); rst_n = 1'b0;
    step();
    n_tests++; if (bus.instr_out !== 16'h0000 || bus.grant_id !== 2'd3) begin n_fail++; $display("FAIL rstmv_after got %h/%0d want 0000/3", bus.instr_out, bus.grant_id); end
    rst_n = 1'b1;
    bus.req_instr = {16'h1070, 16'h1060, 16'h1050};
    bus.req_valid = 3'b111; #1;
    n_tests++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL rstmv_ptr got %b want 001", bus.req_ready); end
    step(); bus.req_valid = 3'b000; #1;
    n_tests++; if (bus.instr_out !== 16'h1050 || bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL rstmv_next got %h/%0d want 1050/0", bus.instr_out, bus.grant_id); end
    step();
    n_tests++; if (bus.instr_out !== 16'h0000) begin n_fail++; $display("FAIL rstmv_idle got %h want 0000", bus.instr_out); end
  endtask

`ifdef PLAYER_IFRAME_EN
  task automatic test_iframe();
    bus.req_instr = {16'h0000, 16'h0000, 16'h2140};
    bus.req_valid = 3'b001; #1;
    n_tests++; if (bus.req_ready !== 3'b001 || bus.iframe_active !== 1'b0) begin n_fail++; $display("FAIL if_c0 got %b/%b want 001/0", bus.req_ready, bus.iframe_active); end
    step(); bus.req_valid = 3'b000; #1;
    n_tests++; if (bus.instr_out !== 16'h2140 || bus.iframe_active !== 1'b1) begin n_fail++; $display("FAIL if_c1 got %h/%b want 2140/1", bus.instr_out, bus.iframe_active); end
    step(); step(); step();
    step(); bus.req_valid = 3'b001; #1;
    step(); bus.req_valid = 3'b000; #1;
    n_tests++; if (bus.drop_pulse !== 1'b1 || bus.instr_out !== 16'h0000 || bus.grant_id !== 2'd3) begin n_fail++; $display("FAIL if_drop got %b/%h/%0d want 1/0000/3", bus.drop_pulse, bus.instr_out, bus.grant_id); end
    step(); tick = 1'b1;
    step(); step(); #1;
    n_tests++; if (bus.iframe_active !== 1'b1) begin n_fail++; $display("FAIL if_c9 got %b want 1", bus.iframe_active); end
    step(); tick = 1'b0; #1;
    n_tests++; if (bus.iframe_active !== 1'b0) begin n_fail++; $display("FAIL if_c10 got %b want 0", bus.iframe_active); end
    bus.req_valid = 3'b001; #1;
    step(); bus.req_valid = 3'b000; #1;
    n_tests++; if (bus.instr_out !== 16'h2140 || bus.drop_pulse !== 1'b0 || bus.iframe_active !== 1'b1) begin n_fail++; $display("FAIL if_c11 got %h/%b/%b want 2140/0/1", bus.instr_out, bus.drop_pulse, bus.iframe_active); end
    step();
  endtask
`else
  task automatic test_dmg_no_iframe();
    bus.req_instr = {16'h0000, 16'h0000, 16'h2140};
    bus.req_valid = 3'b001; #1;
    n_tests++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL dmg_c0_ready got %b want 001", bus.req_ready); end
    step(); bus.req_valid = 3'b000; #1;
    n_tests++; if (bus.instr_out !== 16'h2140 || bus.iframe_active !== 1'b0) begin n_fail++; $display("FAIL dmg_c1 got %h/%b want 2140/0", bus.instr_out, bus.iframe_active); end
    step(); bus.req_valid = 3'b001; #1;
    step(); bus.req_valid = 3'b000; #1;
    n_tests++; if (bus.instr_out !== 16'h2140 || bus.drop_pulse !== 1'b0 || bus.iframe_active !== 1'b0) begin n_fail++; $display("FAIL dmg_c3 got %h/%b/%b want 2140/0/0", bus.instr_out, bus.drop_pulse, bus.iframe_active); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_move_hold();
    test_drop();
    test_reset_during_move();
`ifdef PLAYER_IFRAME_EN
    test_iframe();
`else
    test_dmg_no_iframe();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/player_cmd_arbiter.md
PLAYER_CMD_ARBITER -- requirements
Module: player_cmd_arbiter

Interface
REQ-001 Parameter: IFRAME_TICKS, default 10, number of tick_10hz periods of damage immunity (range 1..255).
REQ-002 clk  in  1  system clock; all logic on its rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 tick_10hz  in  1  one-clk-wide strobe, one per 10 Hz period, in clk domain.
REQ-005 req_valid  in  3  per-requester command valid; bit 0 game FSM, bit 1 collision, bit 2 keyboard.
REQ-006 req_instr  in  48  three 16-bit player instructions, requester k at [16k+15:16k]; [15:12] opcode, [11:4] operand.
REQ-007 req_ready  out  3  one-hot accept; transfer when req_valid[k] and req_ready[k] are both high.
REQ-008 instr_out  out  16  instruction bus driven to the player datapath, registered.
REQ-009 grant_id  out  2  index of the requester whose command is on instr_out; 3 when instr_out is NOP.
REQ-010 drop_pulse  out  1  one-cycle pulse when an accepted command is discarded.
REQ-011 iframe_active  out  1  high while damage immunity is running.

Function
REQ-012 FSM states: IDLE, ISSUE, MOVE_HOLD; only IDLE accepts commands, and req_ready is all-zero outside IDLE.
REQ-013 In IDLE, round-robin among valid requesters starting at pointer rr_ptr; req_ready is combinational, one-hot on the winner.
REQ-014 After an accept from requester k, rr_ptr becomes (k+1) mod 3; rr_ptr is unchanged in cycles with no accept.
REQ-015 Requester holds req_valid and req_instr stable until accepted; a dropped valid before accept is legal and leaves no side effect.
REQ-016 Opcodes 1, 2, 3, 4, 6 accepted in cycle N: instr_out is that instruction for cycle N+1 only (state ISSUE), then 16'h0000 in N+2 (state IDLE).
REQ-017 Opcode 5 (move) accepted in cycle N: instr_out holds it from N+1 in MOVE_HOLD until the first cycle after N with tick_10hz=1 (inclusive); instr_out=16'h0000 in the cycle after that.
REQ-018 tick_10hz coincident with the accept cycle N does not end MOVE_HOLD.
REQ-019 Opcode 0 and opcodes 7..15 are accepted, not issued, and pulse drop_pulse in cycle N+1; state stays IDLE.
REQ-020 Peak throughput: one non-move command per two cycles.
REQ-021 grant_id tracks instr_out in the same cycle.
REQ-022 With PLAYER_IFRAME_EN defined, see REQ-026 and REQ-027.

Reset
REQ-023 When rst_n=0 at a clock edge, the next cycle has state IDLE, instr_out=16'h0000, grant_id=3, rr_ptr=0, drop_pulse=0, iframe counter=0 and iframe_active=0.
REQ-024 During reset req_ready is all-zero.
REQ-025 Reset during ISSUE or MOVE_HOLD aborts the command; the command is not reissued.

Configuration
REQ-026 With PLAYER_IFRAME_EN defined, damage immunity behaves as follows.
- Accepting an opcode-2 command loads the iframe counter with IFRAME_TICKS; the load wins over a coincident tick.
- The counter decrements on each tick_10hz while nonzero.
- iframe_active = (counter != 0).
- While iframe_active=1, opcode-2 commands are accepted and dropped (drop_pulse, no issue); other opcodes are unaffected.
REQ-027 With PLAYER_IFRAME_EN undefined, no counter is built, iframe_active is constant 0, and all opcode-2 commands are issued.

Structure
REQ-028 Shared package player_pkg holds:
- OP_NOP=0, OP_HEAL=1, OP_DMG=2, OP_ATK_ADD=3, OP_ATK_SET=4, OP_MOVE=5, OP_HP_SET=6;
- NUM_REQ=3;
- GRANT_NONE=3;
- the FSM state enumeration.
REQ-029 Round-robin selection is one sub-module, rr_arbiter3 (inputs: req[2:0], ptr[1:0]; outputs: one-hot gnt[2:0], idx[1:0]); the FSM, issue register and iframe counter stay in player_cmd_arbiter.

Verification
REQ-030 Requesters 0, 1 and 2 all valid with heals 16'h1050, 16'h1060, 16'h1070 from reset: accepted in order 0, 1, 2 on alternate cycles; instr_out is 1050/0000/1060/0000/1070.
REQ-031 Keyboard move 16'h5010 accepted at cycle 0, tick at cycles 0 and 7: instr_out=5010 for cycles 1..7 and 0000 at cycle 8; game FSM valid at cycle 3 is accepted at cycle 8.
REQ-032 Requester 1 sends opcode 9 (16'h9000): accepted; drop_pulse=1 one cycle later; instr_out stays 0000; grant_id stays 3.
REQ-033 PLAYER_IFRAME_EN, IFRAME_TICKS=3, two damages 16'h2140 five cycles apart with no tick: first issued, second dropped.
REQ-034 Same setup, three ticks after the first damage: iframe_active falls and the next 16'h2140 is issued.
REQ-035 rst_n low during MOVE_HOLD: next cycle instr_out=0000, grant_id=3, rr_ptr=0; the move is not reissued after reset.
